fft_mdc_bf_stage: RTL and testbench

//  Radix-2 MDC FFT butterfly stage, directly downstream of the input commutator.

---
 rtl/fft_mdc_bf_stage_pkg.sv | 19 +
 rtl/fft_mdc_bf_stage_if.sv | 14 +
 rtl/fft_mdc_bf_stage_delay_line.sv | 18 +
 rtl/fft_mdc_bf_stage.sv | 77 +++++++
 tb/tb_fft_mdc_bf_stage.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fft_mdc_bf_stage_pkg.sv
// fft_mdc_bf_stage_pkg: shared widths, depths and helpers for the MDC FFT stages
// Output width: FFT_MDC_SCALE_EN defined -> OW=width (rounded halving), else OW=width+1.
package fft_mdc_bf_stage_pkg;
`ifdef FFT_MDC_SCALE_EN
  localparam int GROWTH = 0;
`else
  localparam int GROWTH = 1;
`endif
  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 4;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
  function automatic int ow(input int w);
    return w + GROWTH;
  endfunction
endpackage

// File: rtl/fft_mdc_bf_stage_if.sv
// fft_mdc_bf_stage_if: sample-pair input and output streams of one butterfly stage
// master drives in_valid/a_in/b_in and observes out_valid/x_out/y_out; slave is the stage.
interface fft_mdc_bf_stage_if #(parameter int width = 12);
  import fft_mdc_bf_stage_pkg::*;
  localparam int OW = ow(width);
  logic                 in_valid;
  logic signed [width-1:0] a_in;
  logic signed [width-1:0] b_in;
  logic                 out_valid;
  logic signed [OW-1:0] x_out;
  logic signed [OW-1:0] y_out;
  modport master (output in_valid, a_in, b_in, input out_valid, x_out, y_out);
  modport slave (input in_valid, a_in, b_in, output out_valid, x_out, y_out);
endinterface

// File: rtl/fft_mdc_bf_stage_delay_line.sv
// fft_delay_line: enable-gated shift register, q is d delayed by depth enabled cycles
// Ports: clk, rst_n (async active-low), en (shift), d (in), q (oldest entry).
module fft_delay_line #(
  parameter int width = 13,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [depth*width-1:0] sr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else if (en) sr_q <= {sr_q[(depth-1)*width-1:0], d};
  assign q = sr_q[depth*width-1 -: width];
endmodule

// File: rtl/fft_mdc_bf_stage.sv
// fft_mdc_bf_stage: radix-2 MDC butterfly with D-deep delay/switch output commutator
// Ports: clk, rst_n (async active-low), bus (slave: in_valid/a_in/b_in -> out_valid/x_out/y_out).
// FFT_MDC_SCALE_EN selects rounded halving of the butterfly outputs (OW=width) instead of growth.
module fft_mdc_bf_stage
  import fft_mdc_bf_stage_pkg::*;
#(
  parameter int width = 12,
  parameter int D     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_mdc_bf_stage_if.slave   bus
);
  localparam int OW = ow(width);
  localparam int CW = clog2(2 * D);
  // two guard bits: one for the add/sub growth, one so the rounding +1 cannot wrap
  logic signed [width+1:0] a_x, b_x, sum_w, dif_w;
  logic [OW-1:0] s_w, df_w, s_q, d_q, lo_w, up_w, p_w, q_w, x_q, y_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic v1_q, primed_q, primed_d, ov_q, sel;
  assign a_x = {{2{bus.a_in[width-1]}}, bus.a_in};
  assign b_x = {{2{bus.b_in[width-1]}}, bus.b_in};
  assign sum_w = a_x + b_x;
  assign dif_w = a_x - b_x;
`ifdef FFT_MDC_SCALE_EN
  localparam logic signed [width+1:0] ONE = 1;
  logic signed [width+1:0] sum_r, dif_r;
  assign sum_r = sum_w + ONE;
  assign dif_r = dif_w + ONE;
  // (v+1)>>>1 truncated to OW bits is simply bits [OW:1]
  assign s_w  = sum_r[OW:1];
  assign df_w = dif_r[OW:1];
`else
  assign s_w  = sum_w[OW-1:0];
  assign df_w = dif_w[OW-1:0];
`endif
  assign sel = cnt_q[CW-1];
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    primed_d = primed_q | (cnt_q == CW'(D - 1));
    p_w      = sel ? lo_w : s_q;
    q_w      = sel ? s_q : lo_w;
  end
  fft_delay_line #(.width(OW), .depth(D)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(v1_q), .d(d_q), .q(lo_w)
  );
  fft_delay_line #(.width(OW), .depth(D)) u_up (
    .clk(clk), .rst_n(rst_n), .en(v1_q), .d(p_w), .q(up_w)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_q      <= '0;
      d_q      <= '0;
      v1_q     <= 1'b0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ov_q     <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      ov_q <= v1_q & primed_q;
      if (bus.in_valid) begin
        s_q <= s_w;
        d_q <= df_w;
      end
      if (v1_q) begin
        cnt_q    <= cnt_d;
        primed_q <= primed_d;
        x_q      <= up_w;
        y_q      <= q_w;
      end
    end
  assign bus.out_valid = ov_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
endmodule

// File: tb/tb_fft_mdc_bf_stage.sv
// tb_fft_mdc_bf_stage: randomized scoreboard bench for fft_mdc_bf_stage (width=12, D=4)
module tb_fft_mdc_bf_stage;
  import fft_mdc_bf_stage_pkg::*;
  localparam int W  = 12;
  localparam int D  = 4;
  localparam int OW = ow(W);
  typedef struct packed {
    logic signed [OW-1:0] x;
    logic signed [OW-1:0] y;
  } pair_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  int s_hist[$];
  int d_hist[$];
  pair_t exp_q[$];
  bit seen;
  logic signed [OW-1:0] last_x, last_y;
  fft_mdc_bf_stage_if #(.width(W)) bus ();
  fft_mdc_bf_stage #(.width(W), .D(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int bf(input int v);
`ifdef FFT_MDC_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction
  // Result n = k-D of a 2D period: first half x=s(j),y=s(j+D); second half x=d(j),y=d(j+D)
  task automatic accept(input int a, input int b);
    int k, n, m, r;
    pair_t e;
    k = s_hist.size();
    s_hist.push_back(bf(a + b));
    d_hist.push_back(bf(a - b));
    if (k >= D) begin
      n = k - D;
      m = (n / (2 * D)) * (2 * D);
      r = n % (2 * D);
      if (r < D) begin
        e.x = OW'(s_hist[m + r]);
        e.y = OW'(s_hist[m + r + D]);
      end else begin
        e.x = OW'(d_hist[m + r - D]);
        e.y = OW'(d_hist[m + r]);
      end
      exp_q.push_back(e);
    end
  endtask
  task automatic send(input int a, input int b, input bit v);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.a_in = W'(a);
    bus.b_in = W'(b);
    if (v) accept(a, b);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    s_hist.delete();
    d_hist.delete();
    exp_q.delete();
    seen = 1'b0;
    #1;
    chk("rst_now_valid", int'(bus.out_valid), 0);
    chk("rst_now_x", int'(bus.x_out), 0);
    chk("rst_now_y", int'(bus.y_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) send(0, 0, 1'b0);
    repeat (3) send(0, 0, 1'b0);
    chk("drain_left", exp_q.size(), 0);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          pair_t e;
          e = exp_q.pop_front();
          chk("x_out", int'(bus.x_out), int'(e.x));
          chk("y_out", int'(bus.y_out), int'(e.y));
        end
        last_x = bus.x_out;
        last_y = bus.y_out;
        seen = 1'b1;
      end else if (seen) begin
        chk("hold_x", int'(bus.x_out), int'(last_x));
        chk("hold_y", int'(bus.y_out), int'(last_y));
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    seen = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = W'($urandom) != 0;
      bus.a_in = W'($urandom);
      bus.b_in = W'($urandom);
      @(negedge clk);
      chk("reset_valid", int'(bus.out_valid), 0);
      chk("reset_x", int'(bus.x_out), 0);
      chk("reset_y", int'(bus.y_out), 0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(10, 3, 1'b1);
    drain();
    do_reset();
    for (int i = 0; i < 8; i++) send(i[0] ? -2048 : 2047, 2047, 1'b1);
    for (int i = 0; i < 8; i++) send(2047, i[0] ? -2047 : 2047, 1'b1);
    drain();
    do_reset();
    for (int k = 0; k < 24; k++) begin
      send(k, 0, 1'b1);
      send(0, 0, 1'b0);
    end
    drain();
    do_reset();
    for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b1);
    do_reset();
    for (int i = 0; i < 12; i++) send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b1);
    drain();
    do_reset();
    for (int i = 0; i < 24; i++) send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b1);
    drain();
    do_reset();
    for (int i = 0; i < 300; i++)
      send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 3) != 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
